// File: rtl/addressing_sequencer.sv
// Fetch/decode/execute sequencer for the AddressingUnit: holds IR, drives PC select lines,
// memory strobes with wait-state handshaking, and a sticky bus-timeout error.
module addressing_sequencer #(
    parameter int RESET_CYCLES = 2,
    parameter int WAIT_LIMIT   = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        mem_ready,
    input  logic        zero_flag,
    output logic [7:0]  Iside,
    output logic        ResetPC,
    output logic        PCplusI,
    output logic        PCplus1,
    output logic        Iplus0,
    output logic        Rplus0,
    output logic        PCenable,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        rf_wr,
    output logic [15:0] ir,
    output logic        halted,
    output logic        bus_err,
    output logic [2:0]  state
);

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_INCPC  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_BRANCH = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam logic [3:0] OP_LDR  = 4'h1;
    localparam logic [3:0] OP_STR  = 4'h2;
    localparam logic [3:0] OP_LDI  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_BRZ  = 4'h5;
    localparam logic [3:0] OP_JR   = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [15:0] RCNT_LAST = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_LIMIT - 1);

    logic [2:0]  state_d;
    logic [15:0] ir_d;
    logic [15:0] wait_q, wait_d;
    logic [15:0] rcnt_q, rcnt_d;
    logic [3:0]  op;
    logic        rf_wr_d;
    logic        resetpc_d, pcplusi_d, pcplus1_d, iplus0_d, rplus0_d, pcenable_d;
    logic        mem_rd_d, mem_wr_d;

    assign op    = ir[15:12];
    assign Iside = ir[7:0];

    always_comb begin
        state_d = state;
        ir_d    = ir;
        wait_d  = wait_q;
        rcnt_d  = rcnt_q;
        rf_wr_d = 1'b0;
        case (state)
            S_RESET: begin
                if (rcnt_q == RCNT_LAST) state_d = S_FETCH;
                else rcnt_d = rcnt_q + 16'd1;
            end
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = instr;
                    state_d = S_INCPC;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_INCPC: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LDR, OP_STR, OP_LDI: state_d = S_MEM;
                    OP_JMP, OP_JR:          state_d = S_BRANCH;
                    OP_BRZ:                 state_d = zero_flag ? S_BRANCH : S_FETCH;
                    OP_HALT:                state_d = S_HALT;
                    default:                state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                // Ready on the timeout cycle still completes the access.
                if (mem_ready) begin
                    rf_wr_d = (op == OP_LDR) || (op == OP_LDI);
                    state_d = S_FETCH;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = state;
        endcase
        if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state) wait_d = 16'd0;
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        resetpc_d  = 1'b0;
        pcplusi_d  = 1'b0;
        pcplus1_d  = 1'b0;
        iplus0_d   = 1'b0;
        rplus0_d   = 1'b0;
        pcenable_d = 1'b0;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        case (state_d)
            S_RESET: begin
                resetpc_d  = 1'b1;
                pcenable_d = 1'b1;
            end
            S_FETCH: mem_rd_d = 1'b1;
            S_INCPC: begin
                pcplus1_d  = 1'b1;
                pcenable_d = 1'b1;
            end
            S_MEM: begin
                if (op == OP_LDI) iplus0_d = 1'b1;
                else rplus0_d = 1'b1;
                if (op == OP_STR) mem_wr_d = 1'b1;
                else mem_rd_d = 1'b1;
            end
            S_BRANCH: begin
                if (op == OP_JR) rplus0_d = 1'b1;
                else pcplusi_d = 1'b1;
                pcenable_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_RESET;
            ir       <= 16'd0;
            wait_q   <= 16'd0;
            rcnt_q   <= 16'd0;
            ResetPC  <= 1'b1;
            PCplusI  <= 1'b0;
            PCplus1  <= 1'b0;
            Iplus0   <= 1'b0;
            Rplus0   <= 1'b0;
            PCenable <= 1'b1;
            mem_rd   <= 1'b0;
            mem_wr   <= 1'b0;
            rf_wr    <= 1'b0;
            halted   <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state    <= state_d;
            ir       <= ir_d;
            wait_q   <= wait_d;
            rcnt_q   <= rcnt_d;
            ResetPC  <= resetpc_d;
            PCplusI  <= pcplusi_d;
            PCplus1  <= pcplus1_d;
            Iplus0   <= iplus0_d;
            Rplus0   <= rplus0_d;
            PCenable <= pcenable_d;
            mem_rd   <= mem_rd_d;
            mem_wr   <= mem_wr_d;
            rf_wr    <= rf_wr_d;
            halted   <= (state_d == S_HALT);
            bus_err  <= (state_d == S_ERROR);
        end
    end

endmodule

// File: tb/tb_addressing_sequencer.sv
// Directed self-checking bench for addressing_sequencer: compares state plus all control
// outputs per cycle against hand-computed vectors.
module tb_addressing_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = 16'd0;
    logic        mem_ready = 1'b0;
    logic        zero_flag = 1'b0;
    logic [7:0]  Iside;
    logic        ResetPC, PCplusI, PCplus1, Iplus0, Rplus0, PCenable;
    logic        mem_rd, mem_wr, rf_wr, halted, bus_err;
    logic [15:0] ir;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    // {state, ResetPC, PCplusI, PCplus1, Iplus0, Rplus0, PCenable, mem_rd, mem_wr, rf_wr,
    //  halted, bus_err}
    logic [13:0] obs;
    assign obs = {state, ResetPC, PCplusI, PCplus1, Iplus0, Rplus0, PCenable,
                  mem_rd, mem_wr, rf_wr, halted, bus_err};

    localparam logic [13:0] E_RESET    = {3'd0, 11'b10000100000};
    localparam logic [13:0] E_FETCH    = {3'd1, 11'b00000010000};
    localparam logic [13:0] E_FETCH_RF = {3'd1, 11'b00000010100};
    localparam logic [13:0] E_INCPC    = {3'd2, 11'b00100100000};
    localparam logic [13:0] E_DECODE   = {3'd3, 11'b00000000000};
    localparam logic [13:0] E_MEM_LDR  = {3'd4, 11'b00001010000};
    localparam logic [13:0] E_MEM_LDI  = {3'd4, 11'b00010010000};
    localparam logic [13:0] E_MEM_STR  = {3'd4, 11'b00001001000};
    localparam logic [13:0] E_BR_PCI   = {3'd5, 11'b01000100000};
    localparam logic [13:0] E_BR_JR    = {3'd5, 11'b00001100000};
    localparam logic [13:0] E_HALT     = {3'd6, 11'b00000000010};
    localparam logic [13:0] E_ERROR    = {3'd7, 11'b00000000001};

    addressing_sequencer #(.RESET_CYCLES(2), .WAIT_LIMIT(15)) dut (
        .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero_flag(zero_flag),
        .Iside(Iside), .ResetPC(ResetPC), .PCplusI(PCplusI), .PCplus1(PCplus1),
        .Iplus0(Iplus0), .Rplus0(Rplus0), .PCenable(PCenable), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .rf_wr(rf_wr), .ir(ir), .halted(halted), .bus_err(bus_err),
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in its first FETCH cycle with mem_ready low.
    task automatic apply_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
    endtask

    // From FETCH: fetch word w immediately; returns in the DECODE cycle.
    task automatic fetch_to_decode(input logic [15:0] w);
        instr = w;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
    endtask

    task automatic test_reset();
        logic [13:0] exp_seq [3];
        exp_seq = '{E_RESET, E_RESET, E_FETCH};
        rst = 1'b1;
        mem_ready = 1'b0;
        step();
        rst = 1'b0;
        checks++;
        if (ir !== 16'd0) begin
            errors++;
            $display("FAIL reset_ir: got %h expected %h", ir, 16'd0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++;
                $display("FAIL reset_seq[%0d]: got %b expected %b", i, obs, exp_seq[i]);
            end
            if (i < 2) step();
        end
    endtask

    task automatic test_jmp();
        logic [13:0] exp_seq [4];
        exp_seq = '{E_INCPC, E_DECODE, E_BR_PCI, E_FETCH};
        instr = 16'h4010;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        checks++;
        if (ir !== 16'h4010 || Iside !== 8'h10) begin
            errors++;
            $display("FAIL jmp_ir: got ir=%h Iside=%h expected ir=4010 Iside=10", ir, Iside);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== exp_seq[i]) begin
                errors++;
                $display("FAIL jmp_seq[%0d]: got %b expected %b", i, obs, exp_seq[i]);
            end
            if (i < 3) step();
        end
    endtask

    task automatic test_ldr_wait();
        fetch_to_decode(16'h1000);
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs !== E_MEM_LDR) begin
                errors++;
                $display("FAIL ldr_mem[%0d]: got %b expected %b", i, obs, E_MEM_LDR);
            end
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        checks++;
        if (obs !== E_FETCH_RF) begin
            errors++;
            $display("FAIL ldr_rfwr: got %b expected %b", obs, E_FETCH_RF);
        end
        step();
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL ldr_rfwr_drop: got %b expected %b", obs, E_FETCH);
        end
    endtask

    task automatic test_other_ops();
        // LDI with immediate ready
        fetch_to_decode(16'h3000);
        step();
        checks++;
        if (obs !== E_MEM_LDI) begin
            errors++;
            $display("FAIL ldi_mem: got %b expected %b", obs, E_MEM_LDI);
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        checks++;
        if (obs !== E_FETCH_RF) begin
            errors++;
            $display("FAIL ldi_rfwr: got %b expected %b", obs, E_FETCH_RF);
        end
        step();
        // STR: write strobe, no register write
        fetch_to_decode(16'h2000);
        step();
        checks++;
        if (obs !== E_MEM_STR) begin
            errors++;
            $display("FAIL str_mem: got %b expected %b", obs, E_MEM_STR);
        end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL str_done: got %b expected %b", obs, E_FETCH);
        end
        // JR
        fetch_to_decode(16'h6000);
        step();
        checks++;
        if (obs !== E_BR_JR) begin
            errors++;
            $display("FAIL jr_branch: got %b expected %b", obs, E_BR_JR);
        end
        step();
        // NOP: 3 cycles back to FETCH
        fetch_to_decode(16'h0000);
        step();
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL nop_return: got %b expected %b", obs, E_FETCH);
        end
    endtask

    task automatic test_brz();
        zero_flag = 1'b0;
        fetch_to_decode(16'h5005);
        step();
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL brz_not_taken: got %b expected %b", obs, E_FETCH);
        end
        fetch_to_decode(16'h5005);
        zero_flag = 1'b1;
        step();
        zero_flag = 1'b0;
        checks++;
        if (obs !== E_BR_PCI || Iside !== 8'h05) begin
            errors++;
            $display("FAIL brz_taken: got %b Iside=%h expected %b Iside=05",
                     obs, Iside, E_BR_PCI);
        end
        step();
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL brz_return: got %b expected %b", obs, E_FETCH);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        // FETCH cycles 2..15 keep waiting
        for (int i = 2; i <= 15; i++) begin
            step();
            checks++;
            if (obs !== E_FETCH) begin
                errors++;
                $display("FAIL timeout_wait[%0d]: got %b expected %b", i, obs, E_FETCH);
            end
        end
        step();
        mem_ready = 1'b1;
        checks++;
        if (obs !== E_ERROR) begin
            errors++;
            $display("FAIL timeout_err: got %b expected %b", obs, E_ERROR);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== E_ERROR) begin
                errors++;
                $display("FAIL timeout_sticky[%0d]: got %b expected %b", i, obs, E_ERROR);
            end
        end
        // Ready arrives on the 15th FETCH cycle: no error
        apply_reset();
        for (int i = 2; i <= 15; i++) step();
        instr = 16'h0000;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        checks++;
        if (obs !== E_INCPC) begin
            errors++;
            $display("FAIL timeout_ready_wins: got %b expected %b", obs, E_INCPC);
        end
        step();
        step();
        checks++;
        if (obs !== E_FETCH) begin
            errors++;
            $display("FAIL timeout_recover: got %b expected %b", obs, E_FETCH);
        end
    endtask

    task automatic test_halt();
        fetch_to_decode(16'hF000);
        step();
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== E_HALT) begin
                errors++;
                $display("FAIL halt[%0d]: got %b expected %b", i, obs, E_HALT);
            end
            step();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_rst_mid_mem();
        apply_reset();
        fetch_to_decode(16'h1000);
        step();
        checks++;
        if (obs !== E_MEM_LDR) begin
            errors++;
            $display("FAIL rst_mem_enter: got %b expected %b", obs, E_MEM_LDR);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (obs !== E_RESET || ir !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_mem: got %b ir=%h expected %b ir=0000", obs, ir, E_RESET);
        end
    endtask

    initial begin
        test_reset();
        test_jmp();
        test_ldr_wait();
        test_other_ops();
        test_brz();
        test_timeout();
        apply_reset();
        test_halt();
        test_rst_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
